batchg_ctrl: RTL



---
 rtl/batchg_pkg.sv | 27 ++
 rtl/batchg_sync2.sv | 30 +++
 rtl/batchg_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/batchg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : batchg_pkg
// Description : Shared types and constants for the battery-charger controller.
// Revision    : 1.0 - initial release
// ============================================================================
package batchg_pkg;

    localparam int         c_adc_w          = 8;
    localparam logic [7:0] c_softstart_step = 8'd8;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        TRICKLE = 3'd1,
        CC      = 3'd2,
        CV      = 3'd3,
        DONE    = 3'd4,
        FAULT   = 3'd5
    } state_t;

    // States in which current is being forced into the battery.
    function automatic logic is_active(input state_t s);
        return (s == TRICKLE) || (s == CC) || (s == CV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/batchg_sync2.sv
`default_nettype none
// ============================================================================
// Module      : batchg_sync2
// Description : Two-flop synchronizer for a single asynchronous level input.
// Revision    : 1.0 - initial release
// ============================================================================
module batchg_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/batchg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : batchg_ctrl
// Description : Trickle / CC / CV charge state machine driving the current DAC.
//               Optional soft-start CC ramp enabled by BATCHG_SOFTSTART_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module batchg_ctrl
    import batchg_pkg::*;
#(
    parameter logic [c_adc_w-1:0] VTRICKLE        = 8'd96,
    parameter logic [c_adc_w-1:0] VCV             = 8'd200,
    parameter logic [c_adc_w-1:0] VRECHG          = 8'd190,
    parameter logic [c_adc_w-1:0] TMIN            = 8'd40,
    parameter logic [c_adc_w-1:0] TMAX            = 8'd200,
    parameter int                 TIMER_W         = 16,
    parameter logic [TIMER_W-1:0] TIMEOUT_SAMPLES = 16'd60000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [3:0]         sel,
    input  logic               meas_valid,
    input  logic [c_adc_w-1:0] vbat,
    input  logic [c_adc_w-1:0] vtemp,
    output logic [7:0]         icode,
    output logic               dac_en,
    output logic [2:0]         state,
    output logic               done,
    output logic               fault
);

    logic               w_en_s;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_icode;
    logic [7:0]         w_icode_nxt;
    logic [7:0]         r_icc;
    logic [7:0]         w_icc;
    logic [7:0]         w_itrk;
    logic [7:0]         w_iend;
    logic [7:0]         w_cv_code;
    logic [7:0]         w_cc_entry;
    logic [7:0]         w_cc_run;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_inc;
    logic               w_temp_ok;
    logic               w_active;
    logic               w_tick;
    logic               w_timeout;

    batchg_sync2 u_en_sync (
        .clk (clk),
        .rst (rst),
        .d   (en),
        .q   (w_en_s)
    );

    // While OFF the pads are live so the exit edge already sees the new icc.
    assign w_icc       = (r_state == OFF) ? {sel, 4'hF} : r_icc;
    assign w_itrk      = w_icc >> 3;
    assign w_iend      = w_icc >> 4;
    assign w_temp_ok   = (vtemp >= TMIN) && (vtemp <= TMAX);
    assign w_active    = is_active(r_state);
    assign w_tick      = w_active && meas_valid;
    assign w_timer_inc = (&r_timer) ? r_timer : r_timer + 1'b1;
    assign w_timeout   = w_tick && (w_timer_inc == TIMEOUT_SAMPLES);

    always_comb begin
        w_cv_code = r_icode;
        if (vbat > VCV) begin
            w_cv_code = (r_icode == 8'd0) ? 8'd0 : r_icode - 8'd1;
        end else if (vbat < VCV) begin
            w_cv_code = (r_icode >= w_icc) ? w_icc : r_icode + 8'd1;
        end
    end

`ifdef BATCHG_SOFTSTART_EN
    logic [8:0] w_ramp_sum;
    assign w_ramp_sum = {1'b0, r_icode} + {1'b0, c_softstart_step};
    assign w_cc_entry = r_icode;
    assign w_cc_run   = (w_ramp_sum >= {1'b0, w_icc}) ? w_icc : w_ramp_sum[7:0];
`else
    assign w_cc_entry = w_icc;
    assign w_cc_run   = r_icode;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_icode_nxt = r_icode;
        if (!w_en_s) begin
            w_state_nxt = OFF;
            w_icode_nxt = 8'd0;
        end else if (meas_valid) begin
            if ((w_active && !w_temp_ok) || w_timeout) begin
                w_state_nxt = FAULT;
                w_icode_nxt = 8'd0;
            end else begin
                case (r_state)
                    OFF: begin
                        if (!w_temp_ok) begin
                            w_state_nxt = FAULT;
                        end else if (vbat < VTRICKLE) begin
                            w_state_nxt = TRICKLE;
                            w_icode_nxt = w_itrk;
                        end else if (vbat < VCV) begin
                            w_state_nxt = CC;
                            w_icode_nxt = w_cc_entry;
                        end else begin
                            w_state_nxt = CV;
                            w_icode_nxt = w_icc;
                        end
                    end
                    TRICKLE: begin
                        if (vbat >= VTRICKLE) begin
                            w_state_nxt = CC;
                            w_icode_nxt = w_cc_entry;
                        end
                    end
                    CC: begin
                        if (vbat >= VCV) begin
                            w_state_nxt = CV;
                        end else begin
                            w_icode_nxt = w_cc_run;
                        end
                    end
                    CV: begin
                        if (w_cv_code <= w_iend) begin
                            w_state_nxt = DONE;
                            w_icode_nxt = 8'd0;
                        end else begin
                            w_icode_nxt = w_cv_code;
                        end
                    end
                    DONE: begin
                        if (vbat < VRECHG) begin
                            w_state_nxt = CC;
                            w_icode_nxt = w_cc_entry;
                        end
                    end
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OFF;
            r_icode <= 8'd0;
            r_icc   <= 8'd0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_icode <= w_icode_nxt;
            if (r_state == OFF) begin
                r_icc <= {sel, 4'hF};
            end
            if ((r_state == OFF) || (r_state == DONE)) begin
                r_timer <= '0;
            end else if (w_tick) begin
                r_timer <= w_timer_inc;
            end
        end
    end

    assign icode  = r_icode;
    assign dac_en = w_active;
    assign state  = r_state;
    assign done   = (r_state == DONE);
    assign fault  = (r_state == FAULT);

endmodule
`default_nettype wire
